// File: rtl/uart_reg_responder.sv
// ---------------------------------------------------------------------------
// uart_reg_responder
//
// Purpose:
//   Byte-level command responder between a UART receiver and a UART
//   transmitter. Decodes host frames against an internal register file:
//     write: 0x57, addr, data  -> 0x06 (ACK)
//     read : 0x52, addr        -> reg[addr]
//     other opcode / bad addr  -> 0x15 (NAK)
//   Successful writes are announced to fabric logic with a one-cycle
//   strobe, and fabric logic reads the file through a combinational port.
//
// Optional feature (macro UART_RESP_CSUM_EN):
//   Every frame carries a trailing XOR checksum byte, which is checked in an
//   extra CSUM state. Every response is followed by a second byte equal to
//   opcode ^ addr ^ response (addr taken as 0 for an unknown opcode).
//   Undefined: no checksum byte and single-byte responses.
//
// Parameters:
//   DEPTH          number of 8-bit registers (<= 256)
//   TIMEOUT_CYCLES max idle cycles between bytes inside a frame
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   rx_en             receive enable towards the UART receiver
//   rx_data, rx_done  received byte, qualified by a one-cycle pulse
//   tx_data, tx_en    byte to transmit, one-cycle transmit request
//   tx_done           one-cycle pulse when the byte has left the line
//   wr_stb, wr_addr, wr_data  one-cycle register write announcement
//   hw_addr, hw_rdata fabric read port (0 for out-of-range addresses)
//   err               one-cycle pulse on NAK, timeout or overrun
//
// Handshake: all three link signals are pulses, there is no back-pressure.
//   rx_done qualifies rx_data for exactly the cycle it is high; a byte that
//   arrives while rx_en is low is dropped and flagged as an overrun.
//   tx_en is raised for one cycle with tx_data already stable for one cycle;
//   tx_data stays unchanged until the matching tx_done pulse.
// ---------------------------------------------------------------------------
module uart_reg_responder #(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  output logic       rx_en,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] tx_data,
  output logic       tx_en,
  input  logic       tx_done,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] hw_addr,
  output logic [7:0] hw_rdata,
  output logic       err
);

  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [8:0]    DEPTH_LIM = 9'(DEPTH);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_DATA      = 3'd2,
    ST_EXEC      = 3'd3,
    ST_RESP_LOAD = 3'd4,
    ST_RESP_SEND = 3'd5,
    ST_WAIT_TX   = 3'd6
`ifdef UART_RESP_CSUM_EN
    , ST_CSUM    = 3'd7
`endif
  } state_e;

  // State entered after the last payload byte (addr for reads, data for writes).
`ifdef UART_RESP_CSUM_EN
  localparam state_e ST_PAYLOAD_END = ST_CSUM;
`else
  localparam state_e ST_PAYLOAD_END = ST_EXEC;
`endif

  state_e        state_q, state_d;
  logic [7:0]    op_q, op_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [7:0]    regs_q [DEPTH];
  logic [7:0]    regs_d [DEPTH];
`ifdef UART_RESP_CSUM_EN
  logic [7:0]    csum_q, csum_d;
  logic          csum_ok_q, csum_ok_d;
  logic          second_q, second_d;
`endif

  logic          in_frame;
  logic          addr_ok;
  logic          frame_ok;
  logic [AW-1:0] addr_idx;
  logic          rx_en_c, tx_en_c, wr_stb_c, err_c;

  // Byte-collecting states after the opcode; only these run the timeout.
`ifdef UART_RESP_CSUM_EN
  assign in_frame = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign frame_ok = addr_ok && csum_ok_q;
`else
  assign in_frame = (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign frame_ok = addr_ok;
`endif

  assign addr_ok  = ({1'b0, addr_q} < DEPTH_LIM);
  assign addr_idx = addr_q[AW-1:0];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    regs_d    = regs_q;
`ifdef UART_RESP_CSUM_EN
    csum_d    = csum_q;
    csum_ok_d = csum_ok_q;
    second_d  = second_q;
`endif
    tx_en_c   = 1'b0;
    wr_stb_c  = 1'b0;
    err_c     = 1'b0;
    rx_en_c   = (state_q == ST_IDLE) || in_frame;

    case (state_q)
      ST_IDLE: begin
        if (rx_done) begin
          op_d   = rx_data;
          addr_d = '0;
          data_d = '0;
          cnt_d  = '0;
`ifdef UART_RESP_CSUM_EN
          csum_d   = rx_data;
          second_d = 1'b0;
`endif
          if (rx_data == OP_WR || rx_data == OP_RD) begin
            state_d = ST_ADDR;
          end else begin
            // Unknown opcode: NAK right away, nothing more of the frame is read.
            tx_data_d = NAK;
            err_c     = 1'b1;
            state_d   = ST_RESP_LOAD;
          end
        end
      end
      ST_ADDR: begin
        if (rx_done) begin
          addr_d  = rx_data;
          cnt_d   = '0;
`ifdef UART_RESP_CSUM_EN
          csum_d  = csum_q ^ rx_data;
`endif
          state_d = (op_q == OP_WR) ? ST_DATA : ST_PAYLOAD_END;
        end
      end
      ST_DATA: begin
        if (rx_done) begin
          data_d  = rx_data;
          cnt_d   = '0;
`ifdef UART_RESP_CSUM_EN
          csum_d  = csum_q ^ rx_data;
`endif
          state_d = ST_PAYLOAD_END;
        end
      end
`ifdef UART_RESP_CSUM_EN
      ST_CSUM: begin
        if (rx_done) begin
          csum_ok_d = (rx_data == csum_q);
          cnt_d     = '0;
          state_d   = ST_EXEC;
        end
      end
`endif
      ST_EXEC: begin
        if (frame_ok) begin
          if (op_q == OP_WR) begin
            regs_d[addr_idx] = data_q;
            wr_stb_c         = 1'b1;
            tx_data_d        = ACK;
          end else begin
            tx_data_d = regs_q[addr_idx];
          end
        end else begin
          tx_data_d = NAK;
          err_c     = 1'b1;
        end
        state_d = ST_RESP_LOAD;
      end
      // tx_data was loaded on entry here, so it is stable one cycle before tx_en.
      ST_RESP_LOAD: state_d = ST_RESP_SEND;
      ST_RESP_SEND: begin
        tx_en_c = 1'b1;
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (tx_done) begin
`ifdef UART_RESP_CSUM_EN
          if (!second_q) begin
            // Trailer byte: tx_data_q still holds the first response here.
            tx_data_d = op_q ^ addr_q ^ tx_data_q;
            second_d  = 1'b1;
            state_d   = ST_RESP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Inter-byte timeout; a byte arriving on the expiry cycle takes priority.
    if (in_frame && !rx_done) begin
      if (cnt_q == TO_LAST) begin
        cnt_d   = '0;
        err_c   = 1'b1;
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Overrun: a byte arriving while not receiving is dropped.
    if (rx_done && !rx_en_c) begin
      err_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      tx_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
`ifdef UART_RESP_CSUM_EN
      csum_q    <= '0;
      csum_ok_q <= 1'b0;
      second_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      regs_q    <= regs_d;
`ifdef UART_RESP_CSUM_EN
      csum_q    <= csum_d;
      csum_ok_q <= csum_ok_d;
      second_q  <= second_d;
`endif
    end
  end

  // Outputs are forced low while reset is held, even before the first edge.
  assign rx_en   = rx_en_c  & ~rst;
  assign tx_en   = tx_en_c  & ~rst;
  assign wr_stb  = wr_stb_c & ~rst;
  assign err     = err_c    & ~rst;
  assign tx_data = rst ? 8'h00 : tx_data_q;
  assign wr_addr = rst ? 8'h00 : addr_q;
  assign wr_data = rst ? 8'h00 : data_q;

  // Reads the registered file, so a same-cycle write shows up one cycle later.
  assign hw_rdata = ({1'b0, hw_addr} < DEPTH_LIM) ? regs_q[hw_addr[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_uart_reg_responder.sv
// ---------------------------------------------------------------------------
// tb_uart_reg_responder
//
// Drives host frames into uart_reg_responder (DEPTH=16, TIMEOUT_CYCLES=100),
// plays the UART transmitter side (tx_done some cycles after tx_en) and
// compares responses, write strobes, err pulses and the fabric read port
// against a register-file model that applies the protocol rules directly.
// Honours UART_RESP_CSUM_EN when it is defined for both files.
// ---------------------------------------------------------------------------
module tb_uart_reg_responder;

  localparam int DEPTH = 16;
  localparam int TO    = 100;
`ifdef UART_RESP_CSUM_EN
  localparam bit CSUM_MODE = 1'b1;
`else
  localparam bit CSUM_MODE = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       rx_en, rx_done, tx_en, tx_done, wr_stb, err;
  logic [7:0] rx_data, tx_data, wr_addr, wr_data, hw_addr, hw_rdata;

  always #5 clk = ~clk;

  uart_reg_responder #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .rx_en(rx_en), .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .tx_en(tx_en), .tx_done(tx_done),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .hw_addr(hw_addr), .hw_rdata(hw_rdata), .err(err)
  );

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_tx_q[$];
  logic [15:0] exp_wr_q[$];
  logic [15:0] got_wr_q[$];
  logic [7:0]  mem [DEPTH];
  int          err_cnt      = 0;
  int          last_err_cyc = 0;
  int          last_rx_cyc  = 0;
  int          first_tx_cyc = -1;
  bit          tx_busy      = 1'b0;
  int          tx_wait      = 0;
  logic [7:0]  tx_hold_val  = 8'h00;
  logic [7:0]  hw_at_wr     = 8'h00;
  logic [7:0]  hw_after_wr  = 8'h00;
  bit          grab_next    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor and transmitter model, sampled on the falling edge.
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (rst) begin
      tx_busy   = 1'b0;
      grab_next = 1'b0;
    end else begin
      if (rx_done) last_rx_cyc = cyc;
      if (err) begin
        err_cnt++;
        last_err_cyc = cyc;
      end
      if (wr_stb) begin
        got_wr_q.push_back({wr_addr, wr_data});
        hw_at_wr  = hw_rdata;
        grab_next = 1'b1;
      end else if (grab_next) begin
        hw_after_wr = hw_rdata;
        grab_next   = 1'b0;
      end
      if (tx_en) begin
        got_tx_q.push_back(tx_data);
        if (first_tx_cyc < 0) first_tx_cyc = cyc;
        tx_hold_val = tx_data;
        tx_busy     = 1'b1;
        tx_wait     = $urandom_range(4, 8);
      end else if (tx_busy) begin
        if (tx_wait == 0) begin
          check("tx_hold", tx_data, tx_hold_val);
          tx_done = 1'b1;
          tx_busy = 1'b0;
        end else begin
          tx_wait--;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input bit chk_en);
    @(posedge clk); #1;
    if (chk_en) check("rx_en", rx_en, 1'b1);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
    rx_data = 8'($urandom);
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  task automatic wait_idle_tx(input int n_exp);
    for (int i = 0; i < 400 && !(got_tx_q.size() >= n_exp && !tx_busy); i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // One complete frame: build bytes, predict, send, collect, compare.
  task automatic do_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                          input bit bad_cs, input bit inject);
    logic [7:0] bytes[$];
    logic [7:0] resp, cs, old_hw, g;
    logic [15:0] w;
    bit vop, aok, csok, ok;
    int e0, n_exp, exp_err, frame_rx;

    vop  = (op == 8'h57) || (op == 8'h52);
    aok  = (int'(a) < DEPTH);
    csok = 1'b1;
    bytes.push_back(op);
    if (vop) bytes.push_back(a);
    if (op == 8'h57) bytes.push_back(d);
    if (CSUM_MODE && vop) begin
      cs = 8'h00;
      foreach (bytes[i]) cs ^= bytes[i];
      if (bad_cs) begin
        cs   = (cs == 8'h00) ? 8'h01 : 8'h00;
        csok = 1'b0;
      end
      bytes.push_back(cs);
    end
    ok = vop && aok && csok;

    hw_addr = a;
    old_hw  = aok ? mem[int'(a)] : 8'h00;
    if (!ok) begin
      resp = 8'h15;
    end else if (op == 8'h57) begin
      resp = 8'h06;
      mem[int'(a)] = d;
      exp_wr_q.push_back({a, d});
    end else begin
      resp = mem[int'(a)];
    end
    exp_q.push_back(resp);
    if (CSUM_MODE) exp_q.push_back(op ^ (vop ? a : 8'h00) ^ resp);
    n_exp   = exp_q.size();
    exp_err = (ok ? 0 : 1) + (inject ? 1 : 0);

    e0           = err_cnt;
    first_tx_cyc = -1;
    got_tx_q.delete();
    got_wr_q.delete();

    foreach (bytes[i]) send_byte(bytes[i], 1'b1);
    frame_rx = last_rx_cyc;
    if (inject) begin
      for (int i = 0; i < 50 && !tx_busy; i++) @(posedge clk);
      send_byte(8'($urandom), 1'b0);
    end
    wait_idle_tx(n_exp);

    check("tx_count", got_tx_q.size(), n_exp);
    while (exp_q.size() > 0) begin
      g = (got_tx_q.size() > 0) ? got_tx_q.pop_front() : 8'hxx;
      check("tx_byte", g, exp_q.pop_front());
    end
    if (vop) check("latency", first_tx_cyc - frame_rx, 3);
    check("wr_count", got_wr_q.size(), exp_wr_q.size());
    while (exp_wr_q.size() > 0) begin
      w = (got_wr_q.size() > 0) ? got_wr_q.pop_front() : 16'hxxxx;
      check("wr_addr_data", w, exp_wr_q.pop_front());
    end
    if (op == 8'h57 && ok) begin
      check("hw_same_cycle_old", hw_at_wr, old_hw);
      check("hw_next_cycle_new", hw_after_wr, d);
    end
    check("err_count", err_cnt - e0, exp_err);
    check("hw_rdata", hw_rdata, aok ? mem[int'(a)] : 8'h00);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] op, a;
    int e0, t0;
    bit gap_ok;

    rst     = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    hw_addr = 8'h00;
    foreach (mem[i]) mem[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_en", rx_en, 1'b0);
    check("rst_tx_en", tx_en, 1'b0);
    check("rst_wr_stb", wr_stb, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("idle_rx_en", rx_en, 1'b1);
    for (int i = 0; i < 4; i++) begin
      hw_addr = 8'($urandom_range(0, 31));
      #1;
      check("rst_hw_rdata", hw_rdata, 8'h00);
    end

    // Write then read back.
    do_frame(8'h57, 8'h03, 8'hA5, 1'b0, 1'b0);
    do_frame(8'h52, 8'h03, 8'h00, 1'b0, 1'b0);
    // Unknown opcode, then a normal read.
    do_frame(8'h41, 8'h00, 8'h00, 1'b0, 1'b0);
    do_frame(8'h52, 8'h00, 8'h00, 1'b0, 1'b0);
    // Out-of-range addresses, including the first invalid one.
    do_frame(8'h57, 8'h10, 8'hFF, 1'b0, 1'b0);
    do_frame(8'h52, 8'h20, 8'h00, 1'b0, 1'b0);
    do_frame(8'h57, 8'h0F, 8'h5C, 1'b0, 1'b0);
    do_frame(8'h52, 8'h0F, 8'h00, 1'b0, 1'b0);

    // Timeout inside a write frame: one err pulse, nothing sent, nothing written.
    e0 = err_cnt;
    t0 = got_tx_q.size();
    got_wr_q.delete();
    send_byte(8'h57, 1'b1);
    send_byte(8'h05, 1'b1);
    for (int i = 0; i < TO + 20 && err_cnt == e0; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    check("timeout_err", err_cnt - e0, 1);
    gap_ok = (last_err_cyc - last_rx_cyc >= TO - 1) && (last_err_cyc - last_rx_cyc <= TO + 1);
    check("timeout_window", gap_ok, 1'b1);
    check("timeout_no_tx", got_tx_q.size() - t0, 0);
    check("timeout_no_wr", got_wr_q.size(), 0);
    do_frame(8'h52, 8'h05, 8'h00, 1'b0, 1'b0);

    // Overrun while the response is in flight.
    do_frame(8'h52, 8'h03, 8'h00, 1'b0, 1'b1);

    // Reset in the DATA state: the pending write never happens, file cleared.
    do_frame(8'h57, 8'h02, 8'h77, 1'b0, 1'b0);
    got_wr_q.delete();
    send_byte(8'h57, 1'b1);
    send_byte(8'h02, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_rx_en", rx_en, 1'b0);
    check("midrst_wr_stb", wr_stb, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    foreach (mem[i]) mem[i] = 8'h00;
    hw_addr = 8'h02;
    #1;
    check("midrst_hw_rdata", hw_rdata, 8'h00);
    check("midrst_no_wr", got_wr_q.size(), 0);
    do_frame(8'h52, 8'h02, 8'h00, 1'b0, 1'b0);
    do_frame(8'h52, 8'h03, 8'h00, 1'b0, 1'b0);

`ifdef UART_RESP_CSUM_EN
    // Good checksum, then the same frame with a bad one.
    do_frame(8'h57, 8'h01, 8'h3C, 1'b0, 1'b0);
    do_frame(8'h57, 8'h01, 8'h3C, 1'b1, 1'b0);
`endif

    // Randomized frames against the model.
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) begin
        op = 8'h57;
      end else if (r < 8) begin
        op = 8'h52;
      end else begin
        do op = 8'($urandom); while (op == 8'h57 || op == 8'h52);
      end
      a = 8'($urandom_range(0, DEPTH + 3));
      do_frame(op, a, 8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_reg_responder.md
Name: uart_reg_responder

Overview:
- Byte-level command responder. It sits behind a UART receiver (consumes `rx_data`/`rx_done`) and in front of a UART transmitter (drives `tx_data`/`tx_en`, consumes `tx_done`).
- It decodes host read/write frames against an internal register file, sends one-byte responses, and exposes write strobes and a read port to fabric logic.
- It is the device-side counterpart to a host initiating register accesses over the serial link.

Parameters:
- DEPTH, 16, number of 8-bit registers; addresses 0..DEPTH-1 are valid; must be ≤ 256.
- TIMEOUT_CYCLES, 1000000, maximum clk cycles between bytes inside a frame before the frame is discarded.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- rx_en  output  1  receive enable to the UART receiver
- rx_data  input  8  received byte; valid while rx_done=1
- rx_done  input  1  one-cycle pulse, one byte received
- tx_data  output  8  byte to transmit
- tx_en  output  1  one-cycle transmit request
- tx_done  input  1  one-cycle pulse, byte fully transmitted
- wr_stb  output  1  one-cycle pulse on a successful register write
- wr_addr  output  8  address of that write
- wr_data  output  8  data of that write
- hw_addr  input  8  fabric read address
- hw_rdata  output  8  combinational register[hw_addr]; 0 if hw_addr ≥ DEPTH
- err  output  1  one-cycle pulse on NAK, timeout or overrun

Behaviour:

Reset:
- All outputs 0, except `hw_rdata`, which follows the cleared file.
- Register file cleared to 0x00; state IDLE; timeout counter 0.
- Reset mid-frame or mid-transmit aborts immediately; no partial write is performed.

Protocol:
- Write frame: 0x57, addr, data → response 0x06 (ACK).
- Read frame: 0x52, addr → response reg[addr].
- Any other opcode → response 0x15 (NAK) immediately after the opcode byte.
- addr ≥ DEPTH → NAK. For a write frame, the data byte is still consumed before the NAK is sent.

States and transitions:
- IDLE: rx_en=1. On rx_done, latch the opcode → ADDR for 0x52/0x57, else → RESP with NAK.
- ADDR: rx_en=1. On rx_done, latch addr → DATA for a write, EXEC for a read.
- DATA: rx_en=1. On rx_done, latch data → EXEC.
- EXEC (1 cycle):
  - Valid write: update the register and pulse wr_stb/wr_addr/wr_data this cycle.
  - Valid read: load tx_data = reg[addr].
  - Then → RESP.
- RESP: load `tx_data` one cycle before `tx_en`, assert `tx_en` for exactly 1 cycle, → WAIT_TX. `tx_data` is held stable from load until `tx_done`.
- WAIT_TX: rx_en=0; wait for tx_done → IDLE. There is no timeout in this state.

Timing:
- Latency from the final rx_done to tx_en is 3 cycles: EXEC, RESP load, RESP assert.
- Timeout:
  - The counter resets on every rx_done and counts only in ADDR/DATA.
  - On reaching TIMEOUT_CYCLES: discard the frame, pulse err, → IDLE, send nothing.
- A read of an address written by the immediately preceding frame returns the new value.

Overrun:
- rx_done during EXEC/RESP/WAIT_TX: byte dropped, err pulses, state unaffected.
- err also pulses on every NAK (in the cycle the NAK is decided) and on timeout.

Simultaneous events:
- rx_done in the same cycle the timeout fires: the byte wins, the counter resets, no error.
- `hw_rdata` in the same cycle as a write to the same address: returns the old value; the new value is visible the next cycle.

Optional Feature:
- Macro: UART_RESP_CSUM_EN.
- Defined, frame format:
  - Every frame carries a trailing checksum byte = XOR of all preceding frame bytes, received in an extra CSUM state before EXEC.
  - Checksum mismatch → NAK; no write; no wr_stb.
- Defined, responses:
  - Each response is followed by a second byte, the XOR of opcode, addr and response. For NAK on an unknown opcode, this is opcode ^ 0x15.
  - A second RESP/WAIT_TX pass is used for this byte.
- Undefined: no CSUM state; single-byte responses exactly as in Behaviour.

Test Plan:
- Write then read: after reset, rx bytes 0x57,0x03,0xA5 → wr_stb with addr 0x03, data 0xA5; tx 0x06. Then 0x52,0x03 → tx 0xA5; hw_addr=3 gives hw_rdata 0xA5.
- Bad opcode: rx 0x41 → tx 0x15 and err pulse; the next frame 0x52,0x00 → tx 0x00.
- Out-of-range address (DEPTH=16):
  - rx 0x57,0x10,0xFF → tx 0x15, no wr_stb.
  - rx 0x52,0x20 → tx 0x15.
- Timeout: rx 0x57,0x05, then idle for TIMEOUT_CYCLES (bench value 100) → err pulse, no tx_en. A following 0x52,0x05 → tx 0x00.
- Overrun and reset:
  - An rx byte injected during WAIT_TX → err pulse, response unchanged.
  - rst asserted in DATA after 0x57,0x02 → no write; reg[2] reads 0x00.
- With UART_RESP_CSUM_EN:
  - rx 0x57,0x01,0x3C,0x6A → tx 0x06 then 0x50 (0x57^0x01^0x06).
  - The same frame with checksum 0x00 → tx 0x15 then 0x43 (0x57^0x01^0x15), reg unchanged.
